// File: rtl/mul_add_sched_pkg.sv
// Shared types and the round-robin pick helper for the multiply-add scheduler.
package mul_add_sched_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int N_REQ_MAX      = 8;

   typedef logic [$clog2(N_REQ_MAX)-1:0]        req_id_t;
   typedef logic [$clog2(DEF_FIFO_DEPTH+1)-1:0] occ_t;

   // One-hot pick of the first valid requester after 'last', wrapping modulo n.
   function automatic logic [N_REQ_MAX-1:0] rr_next(
      input logic [N_REQ_MAX-1:0] valid,
      input req_id_t              last,
      input int                   n
   );
      logic [N_REQ_MAX-1:0] pick;
      req_id_t              idx;
      pick = '0;
      for (int k = 1; k <= N_REQ_MAX; k++) begin
         idx = req_id_t'((int'(last) + k) % n);
         if (k <= n && pick == '0 && valid[idx]) begin
            pick[idx] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mul_add_sched_core.sv
// Fixed-latency two-stage x*y+z pipeline with a valid bit and tag riding alongside.
module mul_add_core #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vld_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [WIDTH-1:0] z_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] data_o,
   output logic [TAG_W-1:0] tag_o
);

   logic             vld_p0_q, vld_p1_q;
   logic [WIDTH-1:0] x_p0_q, y_p0_q, z_p0_q, sum_p1_q;
   logic [TAG_W-1:0] tag_p0_q, tag_p1_q;

   function automatic logic [WIDTH-1:0] mul_add_lo(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y,
      input logic [WIDTH-1:0] z
   );
      logic [WIDTH-1:0] prod;
      prod = x * y;
      return prod + z;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
      end else begin
         vld_p0_q <= vld_i;
         vld_p1_q <= vld_p0_q;
      end
   end

   always_ff @(posedge clk) begin
      // stage 0: operand capture
      x_p0_q   <= x_i;
      y_p0_q   <= y_i;
      z_p0_q   <= z_i;
      tag_p0_q <= tag_i;
      // stage 1: low-half product plus addend
      sum_p1_q <= mul_add_lo(x_p0_q, y_p0_q, z_p0_q);
      tag_p1_q <= tag_p0_q;
   end

   assign vld_o  = vld_p1_q;
   assign data_o = sum_p1_q;
   assign tag_o  = tag_p1_q;

endmodule

// File: rtl/mul_add_sched.sv
// Round-robin scheduler feeding one shared x*y+z pipeline; credits bound in-flight work to FIFO space.
module mul_add_sched
   import mul_add_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*WIDTH-1:0]   req_x,
   input  logic [N_REQ*WIDTH-1:0]   req_y,
   input  logic [N_REQ*WIDTH-1:0]   req_z,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic                     busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
   } rsp_t;

   logic [OCC_W-1:0] occ_q, occ_d, cnt_q, cnt_d;
   logic [ID_W-1:0]  last_q, last_d, gnt_id;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   rsp_t             hold_q, hold_d, head;
   rsp_t             mem_q [FIFO_DEPTH];
   logic [N_REQ-1:0] gnt;
   logic [WIDTH-1:0] x_sel, y_sel, z_sel, core_data;
   logic [ID_W-1:0]  core_tag;
   logic             accept, pop, core_vld;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Grant is held off while reset is low and whenever every credit is taken.
   always_comb begin
      gnt = '0;
      if (rst_n && occ_q < OCC_W'(FIFO_DEPTH)) begin
         gnt = N_REQ'(rr_next(N_REQ_MAX'(req_valid), req_id_t'(last_q), N_REQ));
      end
   end

   always_comb begin
      gnt_id = '0;
      x_sel  = '0;
      y_sel  = '0;
      z_sel  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_id = ID_W'(i);
            x_sel  = req_x[i*WIDTH +: WIDTH];
            y_sel  = req_y[i*WIDTH +: WIDTH];
            z_sel  = req_z[i*WIDTH +: WIDTH];
         end
      end
   end

   assign req_ready = gnt;
   assign accept    = |(gnt & req_valid);
   assign pop       = (cnt_q != '0) && rsp_ready;

   mul_add_core #(
      .WIDTH (WIDTH),
      .TAG_W (ID_W)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .vld_i  (accept),
      .x_i    (x_sel),
      .y_i    (y_sel),
      .z_i    (z_sel),
      .tag_i  (gnt_id),
      .vld_o  (core_vld),
      .data_o (core_data),
      .tag_o  (core_tag)
   );

   always_comb begin
      occ_d = occ_q;
      case ({accept, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
      cnt_d = cnt_q;
      case ({core_vld, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      last_d   = accept ? gnt_id : last_q;
      wr_ptr_d = core_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      hold_d   = pop ? head : hold_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q    <= '0;
         cnt_q    <= '0;
         last_q   <= ID_W'(N_REQ - 1);
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= hold_d;
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (core_vld) begin
         mem_q[wr_ptr_q] <= '{id: core_tag, data: core_data};
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign rsp_valid = (cnt_q != '0);
   assign rsp_data  = rsp_valid ? head.data : hold_q.data;
   assign rsp_id    = rsp_valid ? head.id : hold_q.id;
   assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_mul_add_sched.sv
// Directed bench for mul_add_sched with a cycle-level reference model and in-order scoreboard.
module tb_mul_add_sched;

   localparam int N = 4;
   localparam int W = 32;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_ready;
   logic [N*W-1:0] req_x, req_y, req_z;
   logic           rsp_valid, rsp_ready, busy;
   logic [W-1:0]   rsp_data;
   logic [1:0]     rsp_id;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   occ_m, fcnt_m, last_m;
   logic s0_m, s1_m;
   exp_t hold_m;

   mul_add_sched #(.N_REQ(N), .WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_z     (req_z),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
      req_z[i*W +: W] = z;
   endtask

   // Reference model: predicts grants, credits, pipeline and FIFO occupancy every cycle.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      logic         acc, pp;
      int           gi;
      logic [W-1:0] xo, yo, zo, ex;
      if (!rst_n) begin
         sb_q.delete();
         occ_m = 0; fcnt_m = 0; last_m = N - 1; s0_m = 1'b0; s1_m = 1'b0; hold_m = '0;
         chk("rst_ready", 64'(req_ready), 64'(0));
         chk("rst_out", 64'({rsp_valid, busy, rsp_id, rsp_data}), 64'(0));
      end else begin
         exp_rdy = '0;
         gi = -1;
         if (occ_m < D) begin
            for (int k = 1; k <= N; k++) begin
               if (gi < 0 && req_valid[(last_m + k) % N]) gi = (last_m + k) % N;
            end
         end
         if (gi >= 0) exp_rdy[gi] = 1'b1;
         chk("mdl_ready", 64'(req_ready), 64'(exp_rdy));
         chk("mdl_busy", 64'(busy), 64'(occ_m != 0));
         chk("mdl_rsp_valid", 64'(rsp_valid), 64'(fcnt_m != 0));
         acc = (gi >= 0);
         pp  = (fcnt_m != 0) && rsp_ready;
         if (fcnt_m != 0 && sb_q.size() > 0) begin
            chk("mdl_rsp", 64'({rsp_id, rsp_data}), 64'(sb_q[0]));
         end else begin
            chk("mdl_hold", 64'({rsp_id, rsp_data}), 64'(hold_m));
         end
         if (pp && sb_q.size() > 0) begin
            hold_m = sb_q.pop_front();
         end
         if (acc) begin
            xo = req_x[gi*W +: W];
            yo = req_y[gi*W +: W];
            zo = req_z[gi*W +: W];
            ex = xo * yo + zo;
            sb_q.push_back('{id: 2'(gi), data: ex});
            last_m = gi;
         end
         fcnt_m = fcnt_m + int'(s1_m) - int'(pp);
         s1_m   = s0_m;
         s0_m   = acc;
         occ_m  = occ_m + int'(acc) - int'(pp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int accepts;
      rst_n     = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_x     = '0;
      req_y     = '0;
      req_z     = '0;
      smp();
      chk("reset_ready", 64'(req_ready), 64'(0));
      chk("reset_outs", 64'({rsp_valid, busy, rsp_id, rsp_data}), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;

      // single op
      set_op(0, 3, 5, 7);
      req_valid = 4'b0001;
      smp(); chk("single_gnt", 64'(req_ready), 64'(4'b0001));
      tick(); req_valid = 4'b0000;
      smp(); chk("single_c1", 64'({busy, rsp_valid}), 64'(2'b10));
      tick();
      smp(); chk("single_c2", 64'({busy, rsp_valid}), 64'(2'b10));
      tick();
      smp(); chk("single_c3", 64'({busy, rsp_valid, rsp_id, rsp_data}), {30'b0, 1'b1, 1'b1, 2'd0, 32'd22});
      tick();
      smp(); chk("single_c4", 64'({busy, rsp_valid, rsp_data}), 64'({1'b0, 1'b0, 32'd22}));

      // wrap-around arithmetic
      tick(); set_op(1, 32'hFFFF_FFFF, 2, 3); req_valid = 4'b0010;
      smp(); chk("wrap_gnt1", 64'(req_ready), 64'(4'b0010));
      tick(); set_op(2, 32'h0001_0000, 32'h0001_0000, 0); req_valid = 4'b0100;
      smp(); chk("wrap_gnt2", 64'(req_ready), 64'(4'b0100));
      tick(); req_valid = 4'b0000;
      smp();
      tick();
      smp(); chk("wrap_rsp1", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd1, 32'h0000_0001}));
      tick();
      smp(); chk("wrap_rsp2", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd2, 32'h0000_0000}));

      // contention from a fresh pointer
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) tick();
         for (int i = 0; i < N; i++) set_op(i, i + 1, c + 10, c);
         req_valid = (c < 8) ? 4'hF : 4'h0;
         smp();
         if (c < 8) chk("cont_gnt", 64'(req_ready), 64'(1 << (c % 4)));
         if (c >= 3) chk("cont_rsp", 64'({rsp_valid, rsp_id}), 64'({1'b1, 2'((c - 3) % 4)}));
      end
      for (int c = 0; c < 3; c++) begin tick(); smp(); end

      // backpressure on requester 1
      accepts = 0;
      for (int c = 0; c <= 21; c++) begin
         tick();
         set_op(1, c, 3, 100);
         req_valid = 4'b0010;
         rsp_ready = (c >= 20);
         smp();
         chk("bp_gnt", 64'(req_ready), 64'((c < 4 || c == 21) ? 4'b0010 : 4'b0000));
         if (c < 20 && req_ready[1]) accepts++;
         if (c == 20) chk("bp_pop_valid", 64'(rsp_valid), 64'(1));
      end
      chk("bp_accepts", 64'(accepts), 64'(D));
      for (int c = 22; c < 28; c++) begin tick(); req_valid = '0; smp(); end

      // idle requesters are skipped
      tick(); set_op(2, 9, 9, 9); req_valid = 4'b0100;
      smp(); chk("skip_gnt2", 64'(req_ready), 64'(4'b0100));
      tick(); set_op(0, 4, 4, 4); req_valid = 4'b0101;
      smp(); chk("skip_gnt0", 64'(req_ready), 64'(4'b0001));
      for (int c = 0; c < 5; c++) begin tick(); req_valid = '0; smp(); end

      // pop and request in the same cycle while full
      for (int c = 0; c <= 7; c++) begin
         tick();
         set_op(3, c + 7, c + 1, 5);
         req_valid = 4'b1000;
         rsp_ready = (c >= 6);
         smp();
         chk("full_gnt", 64'(req_ready), 64'((c < 4 || c == 7) ? 4'b1000 : 4'b0000));
         if (c == 6) chk("full_pop", 64'({rsp_valid, busy}), 64'(2'b11));
      end
      for (int c = 0; c < 7; c++) begin tick(); req_valid = '0; smp(); end

      // reset with three operations in flight
      for (int c = 0; c < 3; c++) begin
         tick();
         set_op(c + 1, c + 2, c + 3, c + 4);
         req_valid = 4'(1 << (c + 1));
         smp(); chk("rst_pre_gnt", 64'(req_ready), 64'(1 << (c + 1)));
      end
      tick();
      req_valid = 4'b0100;
      chk("rst_pre_valid", 64'(rsp_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", 64'({rsp_valid, busy, rsp_id, rsp_data}), 64'(0));
      chk("rst_async_ready", 64'(req_ready), 64'(0));
      smp();
      tick();
      tick();
      rst_n = 1'b1;
      set_op(0, 6, 7, 8);
      req_valid = 4'b0011;
      smp(); chk("rst_first_gnt", 64'(req_ready), 64'(4'b0001));
      for (int c = 1; c <= 3; c++) begin
         tick(); req_valid = '0;
         smp(); chk("rst_no_stale", 64'(rsp_valid), 64'(c == 3));
         if (c == 3) chk("rst_new_rsp", 64'({rsp_id, rsp_data}), 64'({2'd0, 32'd50}));
      end
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
